// File: rtl/sample_rx_fifo_pkg.sv
// Shared DSP constants for the receive sample path; the upstream filter uses
// the same sample width so both ends of the link agree on the data format.
package sample_rx_fifo_pkg;

  localparam int SAMPLE_WIDTH   = 16;
  localparam int FIFO_DEPTH     = 8;
  localparam int DROP_CNT_WIDTH = 16;

  // Per-cycle buffer operation, encoded as {push, pop}
  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_POP  = 2'b01,
    OP_PUSH = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/sample_rx_fifo_mem.sv
// Sample storage: DEPTH x DATA_WIDTH, one synchronous write port and one
// asynchronous read port. Contents are deliberately left unreset.
module sample_mem
  import sample_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [AW-1:0]         i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic [AW-1:0]         i_rd_addr,
  output logic [DATA_WIDTH-1:0] o_rd_data
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  // Synchronous write port
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/sample_rx_fifo.sv
// Receive-side sample buffer: first-word fall-through FIFO with no upstream
// backpressure; samples arriving while full are dropped and counted.
module sample_rx_fifo
  import sample_rx_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = SAMPLE_WIDTH,
  parameter int DEPTH      = FIFO_DEPTH,
  parameter int CNT_WIDTH  = DROP_CNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_WIDTH-1:0]    in_sample,
  input  logic                     in_valid,
  output logic [DATA_WIDTH-1:0]    m_data,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [CNT_WIDTH-1:0]     drop_count,
  input  logic                     clr_overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [LW-1:0]         r_level;
  logic                  r_valid;
  logic                  r_overflow;
  logic [CNT_WIDTH-1:0]  r_drop_count;

  logic                  w_full;
  logic                  w_pop;
  logic                  w_push;
  logic                  w_drop;
  fifo_op_e              w_op;
  logic [LW-1:0]         w_level_nxt;
  logic                  w_ovf_nxt;
  logic [CNT_WIDTH-1:0]  w_cnt_nxt;
  logic [DATA_WIDTH-1:0] w_rd_data;

  sample_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk        (clk),
    .i_wr_en    (w_push),
    .i_wr_addr  (r_wr_ptr),
    .i_wr_data  (in_sample),
    .i_rd_addr  (r_rd_ptr),
    .o_rd_data  (w_rd_data)
  );

  // Handshake decode and next-state for level and drop bookkeeping
  always_comb begin
    w_full      = (r_level == LW'(DEPTH));
    w_pop       = r_valid & m_ready;
    w_push      = in_valid & (~w_full | w_pop);
    w_drop      = in_valid & w_full & ~w_pop;
    w_op        = fifo_op_e'({w_push, w_pop});
    w_level_nxt = r_level;
    w_ovf_nxt   = r_overflow;
    w_cnt_nxt   = r_drop_count;

    case (w_op)
      OP_PUSH: w_level_nxt = r_level + LW'(1);
      OP_POP:  w_level_nxt = r_level - LW'(1);
      OP_BOTH: w_level_nxt = r_level;
      OP_IDLE: w_level_nxt = r_level;
      default: w_level_nxt = r_level;
    endcase

    // A drop in the same cycle as a clear wins, so the new event is never lost
    if (w_drop) begin
      w_ovf_nxt = 1'b1;
      if (clr_overflow) begin
        w_cnt_nxt = CNT_WIDTH'(1);
      end else if (!(&r_drop_count)) begin
        w_cnt_nxt = r_drop_count + CNT_WIDTH'(1);
      end else begin
        w_cnt_nxt = r_drop_count;
      end
    end else if (clr_overflow) begin
      w_ovf_nxt = 1'b0;
      w_cnt_nxt = '0;
    end else begin
      w_ovf_nxt = r_overflow;
      w_cnt_nxt = r_drop_count;
    end
  end

  // Control state: pointers, level, valid flag, overflow and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_level      <= '0;
      r_valid      <= 1'b0;
      r_overflow   <= 1'b0;
      r_drop_count <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_level      <= w_level_nxt;
      r_valid      <= (w_level_nxt != '0);
      r_overflow   <= w_ovf_nxt;
      r_drop_count <= w_cnt_nxt;
    end
  end

  // Unreset storage is masked so m_data reads zero whenever nothing is held
  assign m_data     = r_valid ? w_rd_data : '0;
  assign m_valid    = r_valid;
  assign level      = r_level;
  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;

endmodule

// File: tb/tb_sample_rx_fifo.sv
// Self-checking bench for sample_rx_fifo: queue-based reference model plus a
// negedge monitor, directed boundary scenarios and a randomized phase.
module tb_sample_rx_fifo;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] in_sample;
  logic        in_valid;
  logic [15:0] m_data;
  logic        m_valid;
  logic        m_ready;
  logic [3:0]  level;
  logic        overflow;
  logic [15:0] drop_count;
  logic        clr_overflow;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q [$];
  int          mdl_ovf = 0;
  int          mdl_cnt = 0;

  sample_rx_fifo #(
    .DATA_WIDTH (16),
    .DEPTH      (DEPTH),
    .CNT_WIDTH  (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_sample    (in_sample),
    .in_valid     (in_valid),
    .m_data       (m_data),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .level        (level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [15:0] d, input logic rdy, input logic clr);
    in_valid     = iv;
    in_sample    = d;
    m_ready      = rdy;
    clr_overflow = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a queue of accepted samples and plain drop bookkeeping
  initial begin
    bit pop, full, push, drop;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        exp_q.delete();
        mdl_ovf = 0;
        mdl_cnt = 0;
      end else begin
        pop  = (exp_q.size() != 0) && (m_ready === 1'b1);
        full = (exp_q.size() == DEPTH);
        push = (in_valid === 1'b1) && (!full || pop);
        drop = (in_valid === 1'b1) && full && !pop;
        if (pop) void'(exp_q.pop_front());
        if (push) exp_q.push_back(in_sample);
        if (drop) begin
          mdl_ovf = 1;
          if (clr_overflow === 1'b1) mdl_cnt = 1;
          else if (mdl_cnt < 65535) mdl_cnt = mdl_cnt + 1;
        end else if (clr_overflow === 1'b1) begin
          mdl_ovf = 0;
          mdl_cnt = 0;
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model mid-cycle
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        check("mon_m_valid", 32'(m_valid), 32'(exp_q.size() != 0));
        check("mon_level", 32'(level), 32'(exp_q.size()));
        check("mon_overflow", 32'(overflow), 32'(mdl_ovf));
        check("mon_drop_count", 32'(drop_count), 32'(mdl_cnt));
        if (m_valid === 1'b1 && m_ready === 1'b1 && exp_q.size() != 0)
          check("mon_m_data", 32'(m_data), 32'(exp_q[0]));
      end
    end
  end

  initial begin
    logic [15:0] vals [4];
    logic [15:0] tail [8];
    logic [15:0] held;
    vals = '{16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    in_valid = 1'b0; in_sample = 16'h0000; m_ready = 1'b0; clr_overflow = 1'b0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst_m_valid", 32'(m_valid), 32'd0);
    check("rst_level", 32'(level), 32'd0);
    check("rst_m_data", 32'(m_data), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_drop_count", 32'(drop_count), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Streaming corner values with the consumer always ready
    for (int i = 0; i < 4; i++) begin
      step(1'b1, vals[i], 1'b1, 1'b0);
      check("stream_data", 32'(m_data), 32'(vals[i]));
      check("stream_valid", 32'(m_valid), 32'd1);
      check("stream_level", 32'(level), 32'd1);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("stream_empty", 32'(level), 32'd0);

    // Overfill by two while stalled, then drain in order
    for (int i = 0; i < 10; i++) step(1'b1, 16'h0100 + 16'(i), 1'b0, 1'b0);
    check("ovf_level", 32'(level), 32'd8);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(drop_count), 32'd2);
    for (int i = 0; i < 8; i++) begin
      check("ovf_drain", 32'(m_data), 32'(16'h0100 + 16'(i)));
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end
    check("ovf_drained", 32'(level), 32'd0);

    // Full with simultaneous push and pop
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0200 + 16'(i), 1'b0, 1'b0);
    step(1'b1, 16'h02AA, 1'b1, 1'b0);
    check("fullpp_level", 32'(level), 32'd8);
    check("fullpp_count", 32'(drop_count), 32'd2);
    check("fullpp_head", 32'(m_data), 32'h0201);
    for (int i = 0; i < 7; i++) tail[i] = 16'h0201 + 16'(i);
    tail[7] = 16'h02AA;
    for (int i = 0; i < 8; i++) begin
      check("fullpp_drain", 32'(m_data), 32'(tail[i]));
      step(1'b0, 16'h0000, 1'b1, 1'b0);
    end

    // Counter saturation and clear interactions
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("clr_flag", 32'(overflow), 32'd0);
    check("clr_count", 32'(drop_count), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b1, 16'h0300 + 16'(i), 1'b0, 1'b0);
    for (int i = 0; i < 65535; i++) step(1'b1, 16'hDEAD, 1'b0, 1'b0);
    check("sat_reach", 32'(drop_count), 32'h0000FFFF);
    step(1'b1, 16'hBEEF, 1'b0, 1'b0);
    check("sat_hold", 32'(drop_count), 32'h0000FFFF);
    check("sat_flag", 32'(overflow), 32'd1);
    step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("clr2_flag", 32'(overflow), 32'd0);
    check("clr2_count", 32'(drop_count), 32'd0);
    step(1'b1, 16'hCAFE, 1'b0, 1'b1);
    check("clrdrop_flag", 32'(overflow), 32'd1);
    check("clrdrop_count", 32'(drop_count), 32'd1);

    // Stall: head must hold steady
    held = m_data;
    check("stall_head", 32'(held), 32'h0300);
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b0);
      check("stall_data", 32'(m_data), 32'(held));
      check("stall_valid", 32'(m_valid), 32'd1);
    end

    // Reset mid-operation with five entries held
    for (int i = 0; i < 3; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("pre_rst_level", 32'(level), 32'd5);
    m_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(m_valid), 32'd0);
    check("mid_rst_level", 32'(level), 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step(1'b1, 16'h1234, 1'b0, 1'b0);
    check("post_rst_data", 32'(m_data), 32'h1234);
    check("post_rst_valid", 32'(m_valid), 32'd1);
    check("post_rst_level", 32'(level), 32'd1);

    // Randomized traffic checked by the monitor
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));
    for (int i = 0; i < 10; i++) step(1'b0, 16'h0000, 1'b1, 1'b0);
    check("final_level", 32'(level), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
